register_file: RTL and testbench
================================

// Module: register_file
//
// PURPOSE
//   Multi-entry, multi-port successor to the single clock-enabled register.
//   Holds NUM_REGS words of WIDTH bits with one write port and NUM_RD read
//   ports, per-byte write enables, a global clock enable (stall) and an
//   asynchronous active-low reset. Serves as the CPU's architectural register
//   file between decode (reads) and writeback (writes).
//
// PARAMETERS
//   WIDTH       32    word width in bits; must be a multiple of 8
//   NUM_REGS    16    number of entries (need not be a power of two)
//   NUM_RD      2     number of read ports (1..4)
//   ZERO_REG    0     1: entry 0 reads as 0 and ignores writes
//   RESET_VALUE 0     value loaded into every entry on reset
//   AW          $clog2(NUM_REGS)  address width (derived localparam)
//
// PORTS
//   clk      in   1             clock, all state updates on posedge
//   rst_n    in   1             asynchronous active-low reset
//   clk_en   in   1             global enable; 0 freezes all state
//   wr_en    in   1             write request
//   wr_addr  in   AW            write address
//   wr_be    in   WIDTH/8       byte enables; bit i covers bits [8i+7:8i]
//   wr_data  in   WIDTH         write data
//   rd_addr  in   NUM_RD*AW     packed read addresses, port p at [p*AW +: AW]
//   rd_data  out  NUM_RD*WIDTH  packed read data, port p at [p*WIDTH +: WIDTH]
//   wr_err   out  1             registered flag: last enabled write was dropped
//
// BEHAVIOUR
//   - Reset (rst_n=0, async): every entry <= RESET_VALUE; wr_err <= 0.
//     Entry 0 reads 0 regardless of RESET_VALUE when ZERO_REG=1.
//   - Write: at posedge when clk_en & wr_en & wr_addr<NUM_REGS & !(ZERO_REG &
//     wr_addr==0): entry[wr_addr] byte i <= wr_data byte i for each wr_be[i]=1;
//     other bytes keep their value. wr_be=0 is a legal no-op write.
//   - wr_err: updated only when clk_en=1; <= 1 if wr_en & (wr_addr>=NUM_REGS
//     or ZERO_REG & wr_addr==0), else 0.
//   - clk_en=0: no entry changes and wr_err holds, regardless of wr_en.
//   - Read: combinational, zero latency; rd_data[p] = entry[rd_addr[p]].
//     rd_addr>=NUM_REGS -> 0. ZERO_REG & rd_addr==0 -> 0.
//   - Ports are independent; any number may read the same address.
//   - Same-cycle read/write of one address: see CONFIGURATION.
//   - Reset asserted mid-cycle overrides any write in flight; deassertion
//     takes effect on the next posedge.
//
// CONFIGURATION
//   Macro REGFILE_BYPASS_EN.
//   - Defined: write-to-read forwarding. If clk_en & wr_en and the write is
//     legal and rd_addr[p]==wr_addr, rd_data[p] = stored word with enabled
//     bytes replaced by wr_data (merged next value). Dropped writes are never
//     forwarded.
//   - Undefined: rd_data[p] always returns the stored (pre-write) value; the
//     new value is visible from the cycle after the write edge.
//
// STRUCTURE
//   - regfile_pkg: localparam byte count (WIDTH/8), byte-merge function
//     merge_be(old, new, be), address-legality function.
//   - Sub-module regfile_read_port: one address decode + output mux + optional
//     bypass merge, instantiated NUM_RD times via generate.
//   - Storage is a flat reg array in the top level; one always block with
//     async reset and a per-byte write loop.
//
// TESTING
//   1 Reset: RESET_VALUE=32'hDEAD_BEEF, rst_n=0 -> all ports read DEADBEEF,
//     wr_err=0.
//   2 Byte write: entry 5 = 32'h1122_3344, wr_be=4'b0101, wr_data=32'hAABB_CCDD
//     -> entry 5 reads 32'h11BB_33DD next cycle.
//   3 Stall: clk_en=0, wr_en=1 to entry 3 -> entry 3 unchanged, wr_err holds.
//   4 Zero reg / range: ZERO_REG=1 write 32'hFFFF_FFFF to addr 0 -> reads 0,
//     wr_err=1; NUM_REGS=12, write addr 14 -> no change, wr_err=1; read addr 13 -> 0.
//   5 Same-cycle read/write of addr 7 (old 0, new 32'h0000_0042, wr_be=4'hF):
//     with REGFILE_BYPASS_EN port reads 32'h42 in that cycle; without, reads 0,
//     then 32'h42 next cycle.
//   6 Async reset mid-write: rst_n falls between edges while wr_en=1 -> entry
//     holds RESET_VALUE after next posedge, no write applied.

Source files
------------

// File: rtl/register_file_pkg.sv
// Package regfile_pkg: shared helpers for the register_file slice.
//   MAX_WIDTH / MAX_BYTES : upper bound on word width the helpers handle
//   byte_count(width)     : number of byte lanes in a word
//   merge_be(old,new,be)  : replace the enabled bytes of old with new
//   addr_legal(...)       : address is in range and not the hardwired zero entry
package regfile_pkg;

    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    function automatic int unsigned byte_count(input int unsigned width);
        return width / 8;
    endfunction

    // Operates at MAX_WIDTH; callers widen their operands and cast the result back.
    function automatic logic [MAX_WIDTH-1:0] merge_be(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic addr_legal(
        input int unsigned addr,
        input int unsigned num_regs,
        input logic        zero_reg
    );
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/register_file_read_port.sv
// regfile_read_port: one combinational read port of register_file.
//   i_mem       in   storage array from the top level
//   i_rd_addr   in   read address
//   i_byp_*     in   write-forwarding inputs (only with REGFILE_BYPASS_EN)
//   o_rd_data   out  read word; 0 for out-of-range or hardwired-zero address
// Macro REGFILE_BYPASS_EN adds write-to-read forwarding of the merged word.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned AW       = 4
) (
    input  logic [WIDTH-1:0] i_mem [NUM_REGS],
`ifdef REGFILE_BYPASS_EN
    input  logic             i_byp_en,
    input  logic [AW-1:0]    i_byp_addr,
    input  logic [WIDTH-1:0] i_byp_data,
`endif
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic w_legal;

    always_comb begin
        w_legal   = addr_legal(32'(i_rd_addr), NUM_REGS, ZERO_REG != 0);
        o_rd_data = '0;
        if (w_legal) begin
            o_rd_data = i_mem[i_rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        // i_byp_en already excludes dropped writes, so illegal addresses never match.
        if (i_byp_en && (i_byp_addr == i_rd_addr)) begin
            o_rd_data = i_byp_data;
        end
`endif
    end

endmodule

// File: rtl/register_file.sv
// register_file: NUM_REGS x WIDTH architectural register file, one write port
// with byte enables, NUM_RD combinational read ports, global clock enable.
//   clk, rst_n  clock / asynchronous active-low reset
//   clk_en      0 freezes storage and wr_err
//   wr_en, wr_addr, wr_be, wr_data   write port
//   rd_addr     packed read addresses, port p at [p*AW +: AW]
//   rd_data     packed read data, port p at [p*WIDTH +: WIDTH]
//   wr_err      registered: last enabled write was dropped
// Macro REGFILE_BYPASS_EN: forward the merged write word to matching read ports.
module register_file
    import regfile_pkg::*;
#(
    parameter  int unsigned      WIDTH       = 32,
    parameter  int unsigned      NUM_REGS    = 16,
    parameter  int unsigned      NUM_RD      = 2,
    parameter  int unsigned      ZERO_REG    = 0,
    parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int unsigned      AW          = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH/8-1:0]      wr_be,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic                    wr_err
);

    localparam int unsigned NB = byte_count(WIDTH);

    logic [WIDTH-1:0] r_mem [NUM_REGS];
    logic             r_wr_err;
    logic             w_wr_legal;
    logic             w_wr_fire;

    assign w_wr_legal = addr_legal(32'(wr_addr), NUM_REGS, ZERO_REG != 0);
    assign w_wr_fire  = clk_en && wr_en && w_wr_legal;
    assign wr_err     = r_wr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= RESET_VALUE;
            end
            r_wr_err <= 1'b0;
        end else if (clk_en) begin
            r_wr_err <= wr_en && !w_wr_legal;
            if (w_wr_fire) begin
                for (int unsigned b = 0; b < NB; b++) begin
                    if (wr_be[b]) begin
                        r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [WIDTH-1:0] w_wr_merged;
    assign w_wr_merged = WIDTH'(merge_be(MAX_WIDTH'(r_mem[wr_addr]),
                                         MAX_WIDTH'(wr_data),
                                         MAX_BYTES'(wr_be)));
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_port (
            .i_mem      (r_mem),
`ifdef REGFILE_BYPASS_EN
            .i_byp_en   (w_wr_fire),
            .i_byp_addr (wr_addr),
            .i_byp_data (w_wr_merged),
`endif
            .i_rd_addr  (rd_addr[p*AW +: AW]),
            .o_rd_data  (rd_data[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    localparam int unsigned W   = 32;
    localparam int unsigned NR  = 12;
    localparam int unsigned NRD = 2;
    localparam int unsigned AW  = 4;
    localparam logic [31:0] RV  = 32'hDEAD_BEEF;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clk_en  = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [3:0]    wr_be   = '0;
    logic [31:0]   wr_data = '0;
    logic [7:0]    rd_addr = '0;
    logic [63:0]   rd_data;
    logic          wr_err;

    always #5 clk = ~clk;

    register_file #(
        .WIDTH       (W),
        .NUM_REGS    (NR),
        .NUM_RD      (NRD),
        .ZERO_REG    (1),
        .RESET_VALUE (RV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_err  (wr_err)
    );

    typedef struct {
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_mem [NR];
    logic        m_err;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model: architectural view of the register file.
    function automatic logic legal(input int unsigned a);
        return (a < NR) && (a != 0);
    endfunction

    function automatic logic [31:0] next_word(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] model_read(input int unsigned a);
        logic [31:0] v;
        v = 32'h0;
        if (legal(a)) v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (clk_en && wr_en && legal(wr_addr) && (a == wr_addr))
            v = next_word(m_mem[a], wr_data, wr_be);
`endif
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_mem[i] = RV;
        m_err = 1'b0;
    endtask

    task automatic model_clock();
        if (!rst_n) begin
            model_reset();
        end else if (clk_en) begin
            m_err = wr_en && !legal(wr_addr);
            if (wr_en && legal(wr_addr))
                m_mem[wr_addr] = next_word(m_mem[wr_addr], wr_data, wr_be);
        end
    endtask

    // One cycle: model absorbs the edge, new inputs go out, expected outputs are queued.
    task automatic drive(input logic rst, input logic ce, input logic we,
                         input logic [3:0] wa, input logic [3:0] be, input logic [31:0] wd,
                         input logic [3:0] ra0, input logic [3:0] ra1);
        exp_t e;
        @(posedge clk);
        model_clock();
        #1;
        rst_n   = rst;
        clk_en  = ce;
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_addr = {ra1, ra0};
        if (!rst_n) model_reset();
        e.rd0 = model_read(ra0);
        e.rd1 = model_read(ra1);
        e.err = m_err;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check("rd0", rd_data[31:0], e.rd0);
                check("rd1", rd_data[63:32], e.rd1);
                check("wr_err", {31'b0, wr_err}, {31'b0, e.err});
            end
        end
    end

    initial begin
        model_reset();
        // Reset state
        drive(0, 1, 0, 4'd0, 4'h0, 32'h0, 4'd1, 4'd11);
        drive(0, 1, 1, 4'd2, 4'hF, 32'h1, 4'd0, 4'd13);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd2, 4'd4);
        // Byte write
        drive(1, 1, 1, 4'd5, 4'hF, 32'h1122_3344, 4'd5, 4'd5);
        drive(1, 1, 1, 4'd5, 4'b0101, 32'hAABB_CCDD, 4'd5, 4'd3);
        drive(1, 1, 0, 4'd5, 4'h0, 32'h0, 4'd5, 4'd5);
        // Zero-byte-enable write is a no-op
        drive(1, 1, 1, 4'd5, 4'h0, 32'hFFFF_FFFF, 4'd5, 4'd0);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd0);
        // Zero register, then stall holding wr_err
        drive(1, 1, 1, 4'd3, 4'hF, 32'h1234_5678, 4'd3, 4'd0);
        drive(1, 1, 1, 4'd0, 4'hF, 32'hFFFF_FFFF, 4'd0, 4'd3);
        drive(1, 0, 1, 4'd3, 4'hF, 32'h0BAD_0BAD, 4'd3, 4'd0);
        drive(1, 0, 1, 4'd3, 4'hF, 32'h0BAD_0BAD, 4'd3, 4'd0);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd3, 4'd0);
        // Out-of-range write and read
        drive(1, 1, 1, 4'd14, 4'hF, 32'h5555_5555, 4'd13, 4'd14);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd13, 4'd11);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd1, 4'd11);
        // Same-cycle read/write
        drive(1, 1, 1, 4'd7, 4'hF, 32'h0, 4'd7, 4'd6);
        drive(1, 1, 1, 4'd7, 4'hF, 32'h0000_0042, 4'd7, 4'd7);
        drive(1, 1, 0, 4'd7, 4'h0, 32'h0, 4'd7, 4'd7);
        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  4'($urandom), $urandom, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd1, 4'd2);
        // Async reset falling between edges with a write pending
        drive(1, 1, 1, 4'd5, 4'hF, 32'hCAFE_F00D, 4'd4, 4'd6);
        #5;
        rst_n = 1'b0;
        model_reset();
        drive(0, 1, 0, 4'd5, 4'h0, 32'h0, 4'd5, 4'd0);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd6);
        drive(1, 1, 0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd11);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
